out_fm_tile_writer: RTL and testbench

- Successor to the single-lane output-feature-map FIFO-to-RAM mover.
- Drains one computed output tile from the output FIFO into P banked output RAMs, one FIFO word carrying P channels in parallel.
- Tile position is set at runtime; tile and map dimensions are parameters.
- Sits between the PE array's output FIFO and the output-FM buffer. Writes falling outside the map are suppressed per lane.

---
 rtl/out_fm_tile_writer.sv | 182 ++++++++++++++++++
 tb/tb_out_fm_tile_writer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_fm_tile_writer.sv
// Moves one output tile from the PE-array FIFO into P banked output RAMs, clipping writes outside the map.
// Optional OUT_FM_RELU_EN clamps negative lanes to zero in the output stage.
module out_fm_tile_writer #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned P  = 4,
  parameter int unsigned N  = 32,
  parameter int unsigned R  = 62,
  parameter int unsigned C  = 30,
  parameter int unsigned TN = 8,
  parameter int unsigned TR = 14,
  parameter int unsigned TC = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic [AW-1:0]   tile_base_n,
  input  logic [AW-1:0]   tile_base_row,
  input  logic [AW-1:0]   tile_base_col,
  output logic            fifo_pop,
  input  logic            fifo_empty,
  input  logic [P*DW-1:0] data_from_fifo,
  output logic [P-1:0]    ram_wena,
  output logic [AW-1:0]   ram_addr,
  output logic [P*DW-1:0] data_to_ram
);

  localparam int unsigned G   = TN / P;
  localparam int unsigned WW  = 2 * AW;
  localparam int unsigned TCW = $clog2(TC + 1);
  localparam int unsigned TRW = $clog2(TR + 1);
  localparam int unsigned GW  = $clog2(G + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   bn_q, bn_d, br_q, br_d, bc_q, bc_d;
  logic [TCW-1:0]  tc_q, tc_d;
  logic [TRW-1:0]  tr_q, tr_d;
  logic [GW-1:0]   g_q, g_d;
  logic            s1_valid_q, s1_valid_d;
  logic [AW-1:0]   s1_addr_q, s1_addr_d;
  logic [P-1:0]    s1_en_q, s1_en_d;
  logic [P-1:0]    ram_wena_q, ram_wena_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [P*DW-1:0] data_q, data_d;

  logic            pop;
  logic            last_pop;
  logic [WW-1:0]   blk_full;
  logic [WW-1:0]   row_full;
  logic [WW-1:0]   col_full;
  logic            row_ok;
  logic            col_ok;
  logic [DW-1:0]   lane;

  assign pop      = (state_q == RUN) && !fifo_empty;
  assign last_pop = pop && (tc_q == TCW'(TC - 1)) && (tr_q == TRW'(TR - 1)) && (g_q == GW'(G - 1));

  // Address and per-lane legality for the word being popped this cycle.
  always_comb begin
    blk_full = WW'(bn_q / AW'(P)) + WW'(g_q);
    row_full = WW'(br_q) + WW'(tr_q);
    col_full = WW'(bc_q) + WW'(tc_q);
    row_ok   = row_full < WW'(R);
    col_ok   = col_full < WW'(C);
    s1_addr_d = AW'((blk_full * WW'(R) + row_full) * WW'(C) + col_full);
    s1_en_d   = '0;
    for (int unsigned p = 0; p < P; p++) begin
      s1_en_d[p] = row_ok && col_ok &&
                   ((WW'(bn_q) + WW'(g_q) * WW'(P) + WW'(p)) < WW'(N));
    end
    s1_valid_d = pop;
  end

  always_comb begin
    state_d = state_q;
    bn_d    = bn_q;
    br_d    = br_q;
    bc_d    = bc_q;
    tc_d    = tc_q;
    tr_d    = tr_q;
    g_d     = g_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bn_d    = tile_base_n;
          br_d    = tile_base_row;
          bc_d    = tile_base_col;
          tc_d    = '0;
          tr_d    = '0;
          g_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (pop) begin
          if (tc_q == TCW'(TC - 1)) begin
            tc_d = '0;
            if (tr_q == TRW'(TR - 1)) begin
              tr_d = '0;
              g_d  = g_q + GW'(1);
            end else begin
              tr_d = tr_q + TRW'(1);
            end
          end else begin
            tc_d = tc_q + TCW'(1);
          end
          if (last_pop) state_d = FLUSH;
        end
      end
      // Once stage 1 drains, the output stage holds the final write; DONE lands on the next cycle.
      FLUSH: begin
        if (!s1_valid_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_wena_d = s1_valid_q ? s1_en_q : '0;
    ram_addr_d = ram_addr_q;
    data_d     = data_q;
    lane       = '0;
    if (s1_valid_q) begin
      ram_addr_d = s1_addr_q;
      for (int unsigned p = 0; p < P; p++) begin
        lane = data_from_fifo[p*DW +: DW];
`ifdef OUT_FM_RELU_EN
        if (lane[DW-1]) lane = '0;
`endif
        data_d[p*DW +: DW] = lane;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bn_q       <= '0;
      br_q       <= '0;
      bc_q       <= '0;
      tc_q       <= '0;
      tr_q       <= '0;
      g_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_en_q    <= '0;
      ram_wena_q <= '0;
      ram_addr_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      bn_q       <= bn_d;
      br_q       <= br_d;
      bc_q       <= bc_d;
      tc_q       <= tc_d;
      tr_q       <= tr_d;
      g_q        <= g_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_en_q    <= s1_en_d;
      ram_wena_q <= ram_wena_d;
      ram_addr_q <= ram_addr_d;
      data_q     <= data_d;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == FLUSH);
  assign done        = (state_q == DONE);
  assign fifo_pop    = pop;
  assign ram_wena    = ram_wena_q;
  assign ram_addr    = ram_addr_q;
  assign data_to_ram = data_q;

endmodule

// File: tb/tb_out_fm_tile_writer.sv
// Directed bench for out_fm_tile_writer: table of tile cases plus busy-start, mid-transfer reset and ReLU sequences.
module tb_out_fm_tile_writer;
  localparam int AW = 16, DW = 32, P = 4, N = 32, R = 62, C = 30, TN = 8, TR = 14, TC = 6;
  localparam int NW = TN / P * TR * TC;

  logic            clk = 1'b0;
  logic            rst, start, busy, done, fifo_pop, fifo_empty;
  logic [AW-1:0]   tbn, tbr, tbc, ram_addr;
  logic [P*DW-1:0] data_from_fifo, data_to_ram;
  logic [P-1:0]    ram_wena;

  always #5 clk = ~clk;

  out_fm_tile_writer #(.AW(AW), .DW(DW), .P(P), .N(N), .R(R), .C(C), .TN(TN), .TR(TR), .TC(TC)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .tile_base_n(tbn), .tile_base_row(tbr), .tile_base_col(tbc),
    .fifo_pop(fifo_pop), .fifo_empty(fifo_empty), .data_from_fifo(data_from_fifo),
    .ram_wena(ram_wena), .ram_addr(ram_addr), .data_to_ram(data_to_ram)
  );

  typedef struct {
    int              cyc;
    logic [AW-1:0]   addr;
    logic [P-1:0]    wena;
    logic [P*DW-1:0] data;
  } wr_t;

  typedef struct {
    int bn, br, bc;
    bit stall;
    int expw;
    bit last_legal;
  } case_t;

  wr_t wq[$], eq[$];
  int  cyc = 0, pop_cnt = 0, done_cnt = 0, done_cyc = -1, bad_pop = 0, widx = 0;
  int  n_cmp = 0, n_err = 0;
  bit  relu_mode = 1'b0;
  bit  pop_n = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [P*DW-1:0] mk_word(input int k);
    logic [P*DW-1:0] w;
    for (int p = 0; p < P; p++) begin
      if (relu_mode) w[p*DW +: DW] = (p % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0005;
      else           w[p*DW +: DW] = DW'(k * P + p + 1);
    end
    return w;
  endfunction

  function automatic logic [P*DW-1:0] relu(input logic [P*DW-1:0] w);
    logic [P*DW-1:0] o;
    o = w;
`ifdef OUT_FM_RELU_EN
    for (int p = 0; p < P; p++) if (w[p*DW+DW-1]) o[p*DW +: DW] = '0;
`endif
    return o;
  endfunction

  // FIFO responder: data appears the cycle after a pop.
  always @(negedge clk) pop_n = fifo_pop;
  always @(posedge clk) begin
    #1;
    if (pop_n) begin
      data_from_fifo = mk_word(widx);
      widx++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      wr_t w;
      if (fifo_pop) begin
        pop_cnt++;
        if (fifo_empty) bad_pop++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ram_wena != '0) begin
        w.cyc = cyc; w.addr = ram_addr; w.wena = ram_wena; w.data = data_to_ram;
        wq.push_back(w);
      end
    end
  end

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void build_exp(input int bn, input int br, input int bc);
    wr_t e;
    eq.delete();
    for (int k = 0; k < NW; k++) begin
      int g, tr, tc, a;
      g  = k / (TR * TC);
      tr = (k / TC) % TR;
      tc = k % TC;
      a  = ((bn / P + g) * R + br + tr) * C + bc + tc;
      e.cyc  = 0;
      e.addr = AW'(a);
      for (int p = 0; p < P; p++)
        e.wena[p] = (bn + g * P + p < N) && (br + tr < R) && (bc + tc < C);
      e.data = relu(mk_word(k));
      if (e.wena != '0) eq.push_back(e);
    end
  endfunction

  task automatic run_xfer(input int bn, input int br, input int bc, input bit stall,
                          input bit bstart, output int s);
    int seen;
    wq.delete(); pop_cnt = 0; done_cnt = 0; done_cyc = -1; bad_pop = 0; widx = 0;
    @(posedge clk); #1;
    tbn = AW'(bn); tbr = AW'(br); tbc = AW'(bc);
    start = 1'b1; fifo_empty = 1'b0; s = cyc;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      start = bstart && (cyc == s + 10 || cyc == s + 40 || cyc == s + NW + 3);
      if (bstart && cyc == s + 20) begin
        tbn = AW'(4); tbr = AW'(3); tbc = AW'(2);
      end
      fifo_empty = stall && (cyc % 2 == 1);
      if (done_cnt > 0) seen++;
      if (seen == 4) break;
    end
    start = 1'b0; fifo_empty = 1'b0;
    if (done_cnt == 0) chk_int("timeout waiting for done", done_cnt, 1);
  endtask

  task automatic check_xfer(input string nm, input int bn, input int br, input int bc,
                            input bit stall, input int expw, input bit last_legal, input int s);
    build_exp(bn, br, bc);
    chk_int({nm, " pops"}, pop_cnt, NW);
    chk_int({nm, " done count"}, done_cnt, 1);
    chk_int({nm, " pop while empty"}, bad_pop, 0);
    chk_int({nm, " writes"}, wq.size(), expw);
    chk_int({nm, " model writes"}, eq.size(), expw);
    for (int i = 0; i < wq.size() && i < eq.size(); i++)
      chk_vec($sformatf("%s write%0d addr/wena/data", nm, i),
              {12'h0, wq[i].addr, wq[i].wena, wq[i].data},
              {12'h0, eq[i].addr, eq[i].wena, eq[i].data});
    if (!stall) begin
      if (wq.size() > 0) chk_int({nm, " first write cycle"}, wq[0].cyc - s, 3);
      chk_int({nm, " done cycle"}, done_cyc - s, NW + 3);
    end
    if (last_legal && wq.size() > 0) chk_int({nm, " done after last write"}, done_cyc - wq[wq.size()-1].cyc, 1);
    chk_int({nm, " busy idle"}, int'(busy), 0);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk_int({nm, " busy"}, int'(busy), 0);
    chk_int({nm, " done"}, int'(done), 0);
    chk_int({nm, " fifo_pop"}, int'(fifo_pop), 0);
    chk_int({nm, " ram_wena"}, int'(ram_wena), 0);
    chk_int({nm, " ram_addr"}, int'(ram_addr), 0);
    chk_vec({nm, " data_to_ram"}, {32'h0, data_to_ram}, '0);
  endtask

  initial begin
    case_t tab[5];
    int s, dc;
    tab[0] = '{bn: 0,  br: 0,  bc: 0,  stall: 1'b0, expw: 168, last_legal: 1'b1};
    tab[1] = '{bn: 28, br: 56, bc: 24, stall: 1'b0, expw: 36,  last_legal: 1'b0};
    tab[2] = '{bn: 0,  br: 0,  bc: 27, stall: 1'b0, expw: 84,  last_legal: 1'b0};
    tab[3] = '{bn: 0,  br: 0,  bc: 0,  stall: 1'b1, expw: 168, last_legal: 1'b1};
    tab[4] = '{bn: 4,  br: 60, bc: 0,  stall: 1'b0, expw: 24,  last_legal: 1'b0};

    rst = 1'b1; start = 1'b0; fifo_empty = 1'b1;
    tbn = '0; tbr = '0; tbc = '0; data_from_fifo = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_xfer(tab[i].bn, tab[i].br, tab[i].bc, tab[i].stall, 1'b0, s);
      check_xfer($sformatf("case%0d", i), tab[i].bn, tab[i].br, tab[i].bc,
                 tab[i].stall, tab[i].expw, tab[i].last_legal, s);
    end

    // start while busy, base changes mid-transfer, start during the done cycle
    run_xfer(0, 0, 0, 1'b0, 1'b1, s);
    check_xfer("busy_start", 0, 0, 0, 1'b0, NW, 1'b1, s);

    // reset after 20 pops
    wq.delete(); pop_cnt = 0; done_cnt = 0; bad_pop = 0; widx = 0;
    @(posedge clk); #1;
    tbn = '0; tbr = '0; tbc = '0; start = 1'b1; fifo_empty = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pop_cnt >= 20) break;
      @(posedge clk); #1;
    end
    chk_int("midreset pops before reset", pop_cnt, 20);
    rst = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    dc = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_int("midreset no done", dc + done_cnt, 0);
    chk_int("midreset busy", int'(busy), 0);
    run_xfer(0, 0, 0, 1'b0, 1'b0, s);
    check_xfer("after_reset", 0, 0, 0, 1'b0, NW, 1'b1, s);

    // sign-clamp option: lanes alternate 0xFFFFFFFF / 0x5
    relu_mode = 1'b1;
    run_xfer(0, 0, 0, 1'b0, 1'b0, s);
    check_xfer("relu", 0, 0, 0, 1'b0, NW, 1'b1, s);
    if (wq.size() > 0) begin
`ifdef OUT_FM_RELU_EN
      chk_vec("relu lane0", {128'h0, wq[0].data[31:0]}, {128'h0, 32'h0000_0000});
`else
      chk_vec("relu lane0", {128'h0, wq[0].data[31:0]}, {128'h0, 32'hFFFF_FFFF});
`endif
      chk_vec("relu lane1", {128'h0, wq[0].data[63:32]}, {128'h0, 32'h0000_0005});
    end else begin
      chk_int("relu writes present", wq.size(), NW);
    end
    relu_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
